// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared types and constants for the core memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and load/store,
//            one transaction at a time, data side has priority.
//            Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int XLEN        = core_pkg::XLEN,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    input  logic              if_kill_i,
    output logic [XLEN-1:0]   if_rdata_o,
    output logic              if_valid_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [XLEN-1:0]   d_addr_i,
    input  logic [XLEN-1:0]   d_wdata_i,
    input  logic [XLEN/8-1:0] d_be_i,
    output logic [XLEN-1:0]   d_rdata_o,
    output logic              d_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_be_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              kill_q, kill_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [XLEN/8-1:0] mem_be_q, mem_be_d;
    logic              grant_data;

    if (MAX_D_BURST < 1) begin : g_max_d_burst_check
        $error("MAX_D_BURST must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int BURST_W = $clog2(MAX_D_BURST + 1);

    logic [BURST_W-1:0] burst_q, burst_d;

    // Once the streak reaches the limit a waiting fetch overrides data priority.
    assign grant_data = d_req_i && !(if_req_i && (burst_q == BURST_W'(MAX_D_BURST)));

    always_comb begin
        burst_d = burst_q;
        if (state_q == IDLE) begin
            if (grant_data) begin
                burst_d = if_req_i ? burst_q + BURST_W'(1) : '0;
            end else if (if_req_i) begin
                burst_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign grant_data = d_req_i;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_valid_o  = 1'b0;
        d_valid_o   = 1'b0;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (grant_data) begin
                    owner_d     = DATA;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    mem_be_d    = d_be_i;
                    state_d     = ISSUE;
                end else if (if_req_i) begin
                    owner_d     = FETCH;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (owner_q == FETCH && if_kill_i) kill_d = 1'b1;
                if (mem_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (owner_q == FETCH && if_kill_i) kill_d = 1'b1;
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (owner_q == DATA) begin
                        d_valid_o = 1'b1;
                    end else begin
                        // A flush arriving with the response still discards it.
                        if_valid_o = !(kill_q || if_kill_i);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= FETCH;
            kill_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign mem_req_o   = (state_q == ISSUE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;
    assign stall_if_o  = if_req_i & ~if_valid_o;
    assign stall_mem_o = d_req_i & ~d_valid_o;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_kill_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_rdata_o;
    logic        d_valid_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        stall_if_o;
    logic        stall_mem_o;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .XLEN        (32),
        .MAX_D_BURST (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_kill_i    (if_kill_i),
        .if_rdata_o   (if_rdata_o),
        .if_valid_o   (if_valid_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_be_i       (d_be_i),
        .d_rdata_o    (d_rdata_o),
        .d_valid_o    (d_valid_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .stall_if_o   (stall_if_o),
        .stall_mem_o  (stall_mem_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        if_kill_i    = 1'b0;
        d_req_i      = 1'b0;
        d_we_i       = 1'b0;
        d_addr_i     = '0;
        d_wdata_i    = '0;
        d_be_i       = '0;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req_o); end
        total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%0h exp=0", mem_we_o); end
        total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr_o); end
        total++; if (mem_wdata_o !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata_o); end
        total++; if (mem_be_o !== 4'h0) begin bad++; $display("FAIL rst_mem_be got=%h exp=0", mem_be_o); end
        total++; if ({if_valid_o, d_valid_o} !== 2'b00) begin bad++; $display("FAIL rst_valids got=%b exp=00", {if_valid_o, d_valid_o}); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_lone_fetch();
        if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
        #1;
        total++; if (stall_if_o !== 1'b1) begin bad++; $display("FAIL lone_stall_c0 got=%0h exp=1", stall_if_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL lone_mreq_c0 got=%0h exp=0", mem_req_o); end
        next_cycle();
        mem_ready_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL lone_mreq_c1 got=%0h exp=1", mem_req_o); end
        total++; if (mem_addr_o !== 32'h0000_1000) begin bad++; $display("FAIL lone_maddr got=%h exp=00001000", mem_addr_o); end
        total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL lone_mwe got=%0h exp=0", mem_we_o); end
        total++; if (stall_if_o !== 1'b1) begin bad++; $display("FAIL lone_stall_c1 got=%0h exp=1", stall_if_o); end
        next_cycle();
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0050_0093;
        #1;
        total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL lone_ifvalid got=%0h exp=1", if_valid_o); end
        total++; if (if_rdata_o !== 32'h0050_0093) begin bad++; $display("FAIL lone_ifrdata got=%h exp=00500093", if_rdata_o); end
        total++; if (stall_if_o !== 1'b0) begin bad++; $display("FAIL lone_stall_c2 got=%0h exp=0", stall_if_o); end
        total++; if (d_valid_o !== 1'b0) begin bad++; $display("FAIL lone_dvalid got=%0h exp=0", d_valid_o); end
        next_cycle();
        if_req_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        total++; if ({mem_req_o, if_valid_o} !== 2'b00) begin bad++; $display("FAIL lone_idle_c3 got=%b exp=00", {mem_req_o, if_valid_o}); end
        next_cycle();
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL lone_idle_c4 got=%0h exp=0", mem_req_o); end
    endtask

    task automatic test_priority();
        if_req_i = 1'b1; if_addr_i = 32'h0000_2000;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0100; d_be_i = 4'hF;
        #1;
        total++; if ({stall_if_o, stall_mem_o} !== 2'b11) begin bad++; $display("FAIL prio_stalls_c0 got=%b exp=11", {stall_if_o, stall_mem_o}); end
        next_cycle();
        mem_ready_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL prio_mreq_c1 got=%0h exp=1", mem_req_o); end
        total++; if (mem_addr_o !== 32'h0000_0100) begin bad++; $display("FAIL prio_data_first got=%h exp=00000100", mem_addr_o); end
        next_cycle();
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        total++; if (d_valid_o !== 1'b1) begin bad++; $display("FAIL prio_dvalid got=%0h exp=1", d_valid_o); end
        total++; if (d_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL prio_drdata got=%h exp=deadbeef", d_rdata_o); end
        total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL prio_ifvalid_c2 got=%0h exp=0", if_valid_o); end
        total++; if ({stall_if_o, stall_mem_o} !== 2'b10) begin bad++; $display("FAIL prio_stalls_c2 got=%b exp=10", {stall_if_o, stall_mem_o}); end
        next_cycle();
        d_req_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL prio_mreq_c3 got=%0h exp=0", mem_req_o); end
        next_cycle();
        mem_ready_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL prio_mreq_c4 got=%0h exp=1", mem_req_o); end
        total++; if (mem_addr_o !== 32'h0000_2000) begin bad++; $display("FAIL prio_fetch_addr got=%h exp=00002000", mem_addr_o); end
        next_cycle();
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
        #1;
        total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL prio_ifvalid_c5 got=%0h exp=1", if_valid_o); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_store_stall();
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_0200;
        d_wdata_i = 32'hCAFE_F00D; d_be_i = 4'b0011;
        next_cycle();
        // Scramble the requester side: the port must keep the latched command.
        d_be_i = 4'hF; d_wdata_i = 32'h0; d_we_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            mem_ready_i = (c == 4);
            #1;
            total++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b11_0011) begin bad++; $display("FAIL store_hold_c%0d got=%b exp=110011", c, {mem_req_o, mem_we_o, mem_be_o}); end
            total++; if (mem_wdata_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL store_wdata_c%0d got=%h exp=cafef00d", c, mem_wdata_o); end
            next_cycle();
        end
        mem_ready_i = 1'b0; if_kill_i = 1'b1;
        #1;
        total++; if ({d_valid_o, stall_mem_o, mem_req_o} !== 3'b010) begin bad++; $display("FAIL store_wait got=%b exp=010", {d_valid_o, stall_mem_o, mem_req_o}); end
        next_cycle();
        mem_rvalid_i = 1'b1;
        #1;
        total++; if (d_valid_o !== 1'b1) begin bad++; $display("FAIL store_ack got=%0h exp=1", d_valid_o); end
        next_cycle();
        clear_inputs();
        #1;
        total++; if ({mem_req_o, d_valid_o} !== 2'b00) begin bad++; $display("FAIL store_idle got=%b exp=00", {mem_req_o, d_valid_o}); end
        next_cycle();
    endtask

    task automatic test_kill();
        if_req_i = 1'b1; if_addr_i = 32'h0000_3000;
        next_cycle();
        mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0; if_kill_i = 1'b1;
        #1;
        total++; if ({if_valid_o, stall_if_o} !== 2'b01) begin bad++; $display("FAIL kill_c2 got=%b exp=01", {if_valid_o, stall_if_o}); end
        next_cycle();
        if_kill_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        #1;
        total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL kill_suppress got=%0h exp=0", if_valid_o); end
        total++; if (stall_if_o !== 1'b1) begin bad++; $display("FAIL kill_stall got=%0h exp=1", stall_if_o); end
        next_cycle();
        // Redirected fetch; a flush seen while idle must not taint it.
        mem_rvalid_i = 1'b0; if_addr_i = 32'h0000_4000; if_kill_i = 1'b1;
        #1;
        total++; if ({mem_req_o, if_valid_o} !== 2'b00) begin bad++; $display("FAIL kill_idle got=%b exp=00", {mem_req_o, if_valid_o}); end
        next_cycle();
        if_kill_i = 1'b0; mem_ready_i = 1'b1;
        #1;
        total++; if (mem_addr_o !== 32'h0000_4000) begin bad++; $display("FAIL kill_next_addr got=%h exp=00004000", mem_addr_o); end
        next_cycle();
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0033;
        #1;
        total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL kill_next_valid got=%0h exp=1", if_valid_o); end
        total++; if (if_rdata_o !== 32'h0000_0033) begin bad++; $display("FAIL kill_next_rdata got=%h exp=00000033", if_rdata_o); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_kill_same_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h0000_5000;
        next_cycle();
        mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b1; if_kill_i = 1'b1;
        #1;
        total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL killsame_valid got=%0h exp=0", if_valid_o); end
        next_cycle();
        clear_inputs();
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL killsame_idle got=%0h exp=0", mem_req_o); end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr;
        logic        exp_fetch;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0500; d_be_i = 4'hF;
        if_req_i = 1'b1; if_addr_i = 32'h0000_6000;
        for (int t = 0; t < 5; t++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_fetch = (t == 4);
`else
            exp_fetch = 1'b0;
`endif
            exp_addr = exp_fetch ? 32'h0000_6000 : 32'h0000_0500;
            #1;
            total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL starve_idle_t%0d got=%0h exp=0", t, mem_req_o); end
            next_cycle();
            mem_ready_i = 1'b1;
            #1;
            total++; if (mem_addr_o !== exp_addr) begin bad++; $display("FAIL starve_owner_t%0d got=%h exp=%h", t, mem_addr_o, exp_addr); end
            next_cycle();
            mem_ready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_00AA;
            #1;
            total++; if ({if_valid_o, d_valid_o} !== {exp_fetch, ~exp_fetch}) begin bad++; $display("FAIL starve_valid_t%0d got=%b exp=%b", t, {if_valid_o, d_valid_o}, {exp_fetch, ~exp_fetch}); end
            next_cycle();
            mem_rvalid_i = 1'b0;
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0700; d_be_i = 4'hF;
        next_cycle();
        mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0; rst_n = 1'b0;
        next_cycle();
        d_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        #1;
        total++; if ({if_valid_o, d_valid_o, mem_req_o} !== 3'b000) begin bad++; $display("FAIL rstmid_ctrl got=%b exp=000", {if_valid_o, d_valid_o, mem_req_o}); end
        total++; if ({mem_we_o, mem_addr_o, mem_be_o} !== 37'h0) begin bad++; $display("FAIL rstmid_cmd got=%h exp=0", {mem_we_o, mem_addr_o, mem_be_o}); end
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++; if ({if_valid_o, d_valid_o, mem_req_o} !== 3'b000) begin bad++; $display("FAIL rstmid_late got=%b exp=000", {if_valid_o, d_valid_o, mem_req_o}); end
        next_cycle();
        mem_rvalid_i = 1'b0;
        #1;
        total++; if ({mem_req_o, stall_if_o, stall_mem_o} !== 3'b000) begin bad++; $display("FAIL rstmid_idle got=%b exp=000", {mem_req_o, stall_if_o, stall_mem_o}); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_priority();
        test_store_stall();
        test_kill();
        test_kill_same_cycle();
        test_starvation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
